// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch unit: FSM states, reset PC default,
// instruction field positions and the branch-offset helper.
package mips_pkg;

    // Fetch handshake phases: issue request, await word, hold until retired.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int FUNC_HI  = 5;
    localparam int FUNC_LO  = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int JADDR_HI = 25;
    localparam int JADDR_LO = 0;

    // Sign-extends a 16-bit branch immediate and converts words to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection: jump target, taken branch, or sequential.
module mips_next_pc
    import mips_pkg::*;
(
    input  logic [31:0] i_pc_plus4,
    input  logic [25:0] i_instr_idx,
    input  logic        i_branch,
    input  logic        i_jump,
    input  logic        i_zero,
    output logic [31:0] o_next_pc
);

    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;

    // Jump keeps the current 256 MB region; branch is relative to pc + 4.
    assign w_jump_target   = {i_pc_plus4[31:28], i_instr_idx[JADDR_HI:JADDR_LO], 2'b00};
    assign w_branch_target = i_pc_plus4 + branch_offset(i_instr_idx[IMM_HI:IMM_LO]);

    // Jump has priority over a taken branch; otherwise fall through.
    always_comb begin
        o_next_pc = i_pc_plus4;
        if (i_jump) begin
            o_next_pc = w_jump_target;
        end else if (i_branch && i_zero) begin
            o_next_pc = w_branch_target;
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS fetch unit: owns the PC, fetches one instruction per retire over a
// valid/ready memory port and presents it to control and datapath.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [5:0]  op_out,
    output logic [5:0]  func_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    input  logic        retire_in,
    input  logic        branch_in,
    input  logic        jump_in,
    input  logic        zero_in,
    output logic [31:0] retired_count,
    output logic        err_out
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_instr_valid;
    logic         r_req_valid;
    logic [31:0]  r_count;
    logic         r_err;

    logic         w_rsp_take;
    logic         w_retire_take;
    logic         w_protocol_err;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;

    mips_next_pc u_next_pc (
        .i_pc_plus4  (w_pc_plus4),
        .i_instr_idx (r_instr[JADDR_HI:JADDR_LO]),
        .i_branch    (branch_in),
        .i_jump      (jump_in),
        .i_zero      (zero_in),
        .o_next_pc   (w_next_pc)
    );

    // Next-state logic: advance on request accept, response and retire.
    always_comb begin
        w_next_state  = r_state;
        w_rsp_take    = 1'b0;
        w_retire_take = 1'b0;
        case (r_state)
            S_REQ: begin
                if (r_req_valid && imem_req_ready) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_rsp_take   = 1'b1;
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (retire_in) begin
                    w_retire_take = 1'b1;
                    w_next_state  = S_REQ;
                end
            end
            default: begin
                w_next_state = S_REQ;
            end
        endcase
    end

    // A response or retire arriving in the wrong phase is ignored but flagged.
    assign w_protocol_err = (imem_rsp_valid && (r_state != S_WAIT)) ||
                            (retire_in && (r_state != S_HOLD));

    // State, PC, instruction, counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_req_valid   <= 1'b0;
            r_count       <= 32'd0;
            r_err         <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_req_valid <= (w_next_state == S_REQ);
            if (w_rsp_take) begin
                r_instr       <= imem_rsp_data;
                r_instr_valid <= 1'b1;
            end
            if (w_retire_take) begin
                r_pc          <= w_next_pc;
                r_instr_valid <= 1'b0;
                r_count       <= r_count + 32'd1;
            end
            if (w_protocol_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;
    assign instr_valid    = r_instr_valid;
    assign instr_out      = r_instr;
    assign op_out         = r_instr[OP_HI:OP_LO];
    assign func_out       = r_instr[FUNC_HI:FUNC_LO];
    assign pc_out         = r_pc;
    assign pc_plus4_out   = w_pc_plus4;
    assign retired_count  = r_count;
    assign err_out        = r_err;

endmodule
